vx_mem_responder: RTL and testbench

- Line-granular memory slave that terminates the memory-side master port of a cache (the mem_bus master of the cache wrapper).
- Accepts one request per cycle: reads or byte-enabled writes to an on-chip line array.
- Returns read data with the request tag after a fixed pipeline latency, through a credit-protected response queue.
- Used as the backing store in cache-level benches and as a small on-chip memory behind a cache.

---
 rtl/vx_mem_responder.sv | 133 +++++++++++++
 tb/tb_vx_mem_responder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/vx_mem_responder.sv
// Line-granular memory slave with byte-enabled writes and fixed-latency reads.
// Read responses pass through a delay line into a credit-protected response queue.
module vx_mem_responder #(
  parameter int LINE_SIZE      = 64,
  parameter int ADDR_WIDTH     = 26,
  parameter int TAG_WIDTH      = 8,
  parameter int DEPTH          = 1024,
  parameter int LATENCY        = 4,
  parameter int RSP_QUEUE_SIZE = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_req_valid,
  input  logic                    mem_req_rw,
  input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
  input  logic [LINE_SIZE-1:0]    mem_req_byteen,
  input  logic [8*LINE_SIZE-1:0]  mem_req_data,
  input  logic [TAG_WIDTH-1:0]    mem_req_tag,
  output logic                    mem_req_ready,
  output logic                    mem_rsp_valid,
  output logic [8*LINE_SIZE-1:0]  mem_rsp_data,
  output logic [TAG_WIDTH-1:0]    mem_rsp_tag,
  input  logic                    mem_rsp_ready,
  output logic                    busy
);

  localparam int DATA_W = 8 * LINE_SIZE;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(RSP_QUEUE_SIZE + 1);
  localparam int PTR_W  = (RSP_QUEUE_SIZE > 1) ? $clog2(RSP_QUEUE_SIZE) : 1;
  localparam logic [CNT_W-1:0] CREDITS  = CNT_W'(RSP_QUEUE_SIZE);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RSP_QUEUE_SIZE - 1);

  logic [DATA_W-1:0]    mem [DEPTH];
  logic [IDX_W-1:0]     idx;
  logic                 rd_fire;
  logic                 wr_fire;
  logic                 push;
  logic                 pop;
  logic [CNT_W-1:0]     cnt;

  logic [LATENCY-1:0]   st_valid;
  logic [DATA_W-1:0]    st_data [LATENCY];
  logic [TAG_WIDTH-1:0] st_tag  [LATENCY];

  logic [DATA_W-1:0]    q_data [RSP_QUEUE_SIZE];
  logic [TAG_WIDTH-1:0] q_tag  [RSP_QUEUE_SIZE];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     q_cnt;

  assign idx     = mem_req_addr[IDX_W-1:0];
  assign mem_req_ready = (cnt < CREDITS);
  assign rd_fire = mem_req_valid & mem_req_ready & ~mem_req_rw;
  assign wr_fire = mem_req_valid & mem_req_ready & mem_req_rw;
  assign push    = st_valid[LATENCY-1];
  assign pop     = mem_rsp_valid & mem_rsp_ready;
  assign busy    = (cnt != '0);

  // Upper address bits alias onto the same lines.
  if (ADDR_WIDTH > IDX_W) begin : g_alias
    logic unused_upper;
    assign unused_upper = |mem_req_addr[ADDR_WIDTH-1:IDX_W];
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int b = 0; b < LINE_SIZE; b++) begin
        if (mem_req_byteen[b]) mem[idx][8*b +: 8] <= mem_req_data[8*b +: 8];
      end
    end
  end

  // Credits count reads accepted but not yet handed to the consumer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      case ({rd_fire, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_valid <= '0;
    end else begin
      st_valid[0] <= rd_fire;
      for (int i = 1; i < LATENCY; i++) st_valid[i] <= st_valid[i-1];
    end
  end

  always_ff @(posedge clk) begin
    st_data[0] <= mem[idx];
    st_tag[0]  <= mem_req_tag;
    for (int i = 1; i < LATENCY; i++) begin
      st_data[i] <= st_data[i-1];
      st_tag[i]  <= st_tag[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr] <= st_data[LATENCY-1];
      q_tag[wr_ptr]  <= st_tag[LATENCY-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_cnt  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   q_cnt <= q_cnt + CNT_W'(1);
        2'b01:   q_cnt <= q_cnt - CNT_W'(1);
        default: q_cnt <= q_cnt;
      endcase
    end
  end

  // Head is masked to zero when empty so stale storage never shows.
  assign mem_rsp_valid = (q_cnt != '0);
  assign mem_rsp_data  = mem_rsp_valid ? q_data[rd_ptr] : '0;
  assign mem_rsp_tag   = mem_rsp_valid ? q_tag[rd_ptr]  : '0;

endmodule

// File: tb/tb_vx_mem_responder.sv
// Directed bench for vx_mem_responder: reference line model plus an in-order
// response scoreboard filled on read accept and drained on response handshake.
module tb_vx_mem_responder;

  localparam int DW = 512;

  typedef struct packed {
    logic [7:0]    tag;
    logic [DW-1:0] data;
  } rsp_t;

  logic          clk;
  logic          reset;
  logic          mem_req_valid;
  logic          mem_req_rw;
  logic [25:0]   mem_req_addr;
  logic [63:0]   mem_req_byteen;
  logic [DW-1:0] mem_req_data;
  logic [7:0]    mem_req_tag;
  logic          mem_req_ready;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_data;
  logic [7:0]    mem_rsp_tag;
  logic          mem_rsp_ready;
  logic          busy;

  int tests = 0;
  int fails = 0;
  int acc_cnt = 0;
  rsp_t sb[$];
  logic [DW-1:0] model [1024];

  vx_mem_responder dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_byteen(mem_req_byteen),
    .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag),
    .mem_rsp_ready(mem_rsp_ready), .busy(busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Issue one request, holding valid until accepted (bounded).
  task automatic req(input logic rw_i, input logic [25:0] a, input logic [63:0] be,
                     input logic [DW-1:0] d, input logic [7:0] t, output int waits);
    logic ok;
    ok = 0;
    waits = 0;
    mem_req_valid = 1; mem_req_rw = rw_i; mem_req_addr = a;
    mem_req_byteen = be; mem_req_data = d; mem_req_tag = t;
    while (!ok && waits < 200) begin
      @(negedge clk);
      if (mem_req_ready) ok = 1; else waits++;
    end
    @(posedge clk);
    tests++;
    assert (ok) else begin
      fails++;
      $error("FAIL req_timeout: observed no accept expected accept addr %0h", a);
    end
    if (ok) begin
      acc_cnt++;
      if (rw_i) begin
        for (int b = 0; b < 64; b++)
          if (be[b]) model[a[9:0]][8*b +: 8] = d[8*b +: 8];
      end else begin
        sb.push_back('{tag: t, data: model[a[9:0]]});
      end
    end
    #1 mem_req_valid = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || mem_rsp_valid) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    tests++;
    assert (n < 300) else begin
      fails++;
      $error("FAIL drain_timeout: observed %0d pending expected 0", sb.size());
    end
  endtask

  // Response monitor: every handshake must match the oldest outstanding read.
  always @(negedge clk) begin
    rsp_t e;
    if (!reset && mem_rsp_valid && mem_rsp_ready) begin
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_rsp: observed tag %0h expected no response", mem_rsp_tag);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rsp_tag", DW'(mem_rsp_tag), DW'(e.tag));
        chk("rsp_data", mem_rsp_data, e.data);
      end
    end
  end

  localparam logic [DW-1:0] PAT_A = {16{32'hA5C3_0F1E}};
  localparam logic [DW-1:0] PAT_B = {16{32'h0B0B_1234}};
  localparam logic [DW-1:0] PAT_C = {64{8'hCC}};

  initial begin
    int w, n, base, stalls, busy_drops;
    reset = 1; mem_req_valid = 0; mem_req_rw = 0; mem_req_addr = '0;
    mem_req_byteen = '0; mem_req_data = '0; mem_req_tag = '0; mem_rsp_ready = 1;

    #12;
    chk("rst_rsp_valid", DW'(mem_rsp_valid), '0);
    chk("rst_busy", DW'(busy), '0);
    chk("rst_rsp_data", mem_rsp_data, '0);
    chk("rst_rsp_tag", DW'(mem_rsp_tag), '0);
    @(negedge clk); @(negedge clk); #2 reset = 0;
    @(posedge clk); #1;
    chk("rst_ready", DW'(mem_req_ready), DW'(1));

    // Write then read same line; response exactly LATENCY cycles after accept.
    req(1, 26'h5, '1, PAT_A, 8'h00, w);
    req(0, 26'h5, '0, '0, 8'h3C, w);
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      chk("lat_valid", DW'(mem_rsp_valid), DW'(i == 4));
    end
    drain();

    // Partial write through an aliased address.
    req(1, 26'h7, '1, {64{8'hFF}}, 8'h00, w);
    req(1, 26'h407, 64'h1, '0, 8'h00, w);
    req(0, 26'h7, '0, '0, 8'h11, w);
    drain();

    // Read sampled before a following write to the same line.
    req(1, 26'h9, '1, PAT_B, 8'h00, w);
    req(0, 26'h9, '0, '0, 8'h22, w);
    req(1, 26'h9, '1, PAT_C, 8'h00, w);
    req(0, 26'h9, '0, '0, 8'h23, w);
    drain();

    for (int i = 0; i < 100; i++)
      req(1, 26'h100 + 26'(i), '1, {16{32'(i) ^ 32'h5A5A_0000}}, 8'h00, w);

    // Backpressure: only RSP_QUEUE_SIZE reads fit until a response is popped.
    mem_rsp_ready = 0;
    base = acc_cnt;
    fork
      begin
        for (int i = 0; i < 10; i++) req(0, 26'h100 + 26'(i), '0, '0, 8'h80 + 8'(i), w);
      end
      begin
        n = 0;
        while (acc_cnt - base < 8 && n < 50) begin @(posedge clk); #2; n++; end
        @(negedge clk);
        chk("bp_ready_after_8", DW'(mem_req_ready), '0);
        repeat (4) @(negedge clk);
        chk("bp_accepts", DW'(acc_cnt - base), DW'(8));
        chk("bp_ready_hold", DW'(mem_req_ready), '0);
        chk("bp_busy", DW'(busy), DW'(1));
        @(posedge clk); #1 mem_rsp_ready = 1;
        @(negedge clk);
        chk("bp_ready_before_pop", DW'(mem_req_ready), '0);
        @(negedge clk);
        chk("bp_ready_after_pop", DW'(mem_req_ready), DW'(1));
      end
    join
    drain();
    chk("bp_total_accepts", DW'(acc_cnt - base), DW'(10));

    // Streaming at one read per cycle.
    stalls = 0; busy_drops = 0;
    for (int i = 0; i < 100; i++) begin
      req(0, 26'h100 + 26'(i), '0, '0, 8'(i), w);
      stalls += w;
      if (!busy) busy_drops++;
    end
    chk("stream_stalls", DW'(stalls), '0);
    chk("stream_busy_drops", DW'(busy_drops), '0);
    drain();
    @(negedge clk);
    chk("stream_idle_busy", DW'(busy), '0);

    // Reset with reads in flight and queued.
    mem_rsp_ready = 0;
    req(0, 26'h100, '0, '0, 8'hA0, w);
    req(0, 26'h101, '0, '0, 8'hA1, w);
    req(0, 26'h102, '0, '0, 8'hA2, w);
    repeat (6) @(posedge clk);
    #3;
    chk("pre_rst_valid", DW'(mem_rsp_valid), DW'(1));
    reset = 1;
    #1;
    chk("mid_rst_valid", DW'(mem_rsp_valid), '0);
    chk("mid_rst_busy", DW'(busy), '0);
    chk("mid_rst_tag", DW'(mem_rsp_tag), '0);
    sb.delete();
    @(negedge clk); @(negedge clk); #2 reset = 0;
    mem_rsp_ready = 1;
    @(posedge clk); #1;
    chk("post_rst_ready", DW'(mem_req_ready), DW'(1));
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_valid", DW'(mem_rsp_valid), '0);
    chk("post_rst_busy", DW'(busy), '0);
    req(0, 26'h5, '0, '0, 8'h55, w);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
